hex_seg_scan: RTL and testbench

//  Downstream display stage of the hex counter: takes the 16-bit count and drives the shared 12-bit SEG bus.

---
 rtl/hexcnt_pkg.sv | 31 +++
 rtl/hex_seg_scan_if.sv | 15 +
 rtl/hex_seg_scan_hex_to_seg7.sv | 32 +++
 rtl/hex_seg_scan.sv | 112 +++++++++++
 tb/tb_hex_seg_scan.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/hexcnt_pkg.sv
// Shared constants for the hex counter display path: SEG bit layout, scan state
// encoding and the leading-zero lit-mask helper.
package hexcnt_pkg;

  localparam int unsigned SEG_W  = 12;
  localparam int unsigned AN_MSB = 11;
  localparam int unsigned AN_LSB = 8;
  localparam int unsigned DP_BIT = 7;
  localparam int unsigned FONT_W = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DIG_N  = 4;
  localparam int unsigned VAL_W  = NIB_W * DIG_N;

  localparam logic [SEG_W-1:0] SEG_OFF = 12'hFFF;

  typedef enum logic {
    ST_DEAD   = 1'b0,
    ST_ACTIVE = 1'b1
  } scan_state_e;

  // Digit i is lit when it or any more significant nibble is nonzero; digit0 always lit.
  function automatic logic [DIG_N-1:0] lead_lit(input logic [VAL_W-1:0] v);
    logic [DIG_N-1:0] m;
    m[3] = (v[15:12] != 4'h0);
    m[2] = m[3] | (v[11:8] != 4'h0);
    m[1] = m[2] | (v[7:4] != 4'h0);
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hex_seg_scan_if.sv
// Display-side bus of hex_seg_scan: value/load/dp/blank in, multiplexed SEG and FRAME out.
interface hex_seg_scan_if;
  import hexcnt_pkg::*;

  logic [VAL_W-1:0] value;
  logic             load;
  logic [DIG_N-1:0] dp_mask;
  logic             blank;
  logic [SEG_W-1:0] seg;
  logic             frame;

  modport master (output value, load, dp_mask, blank, input seg, frame);
  modport slave  (input value, load, dp_mask, blank, output seg, frame);

endinterface

// File: rtl/hex_seg_scan_hex_to_seg7.sv
// Combinational hex nibble to 7-segment font, active-low {G,F,E,D,C,B,A}.
module hex_to_seg7
  import hexcnt_pkg::*;
(
  input  logic [NIB_W-1:0]  nib,
  output logic [FONT_W-1:0] font_c
);

  always_comb begin
    font_c = 7'h7F;
    case (nib)
      4'h0: font_c = 7'h40;
      4'h1: font_c = 7'h79;
      4'h2: font_c = 7'h24;
      4'h3: font_c = 7'h30;
      4'h4: font_c = 7'h19;
      4'h5: font_c = 7'h12;
      4'h6: font_c = 7'h02;
      4'h7: font_c = 7'h78;
      4'h8: font_c = 7'h00;
      4'h9: font_c = 7'h10;
      4'hA: font_c = 7'h08;
      4'hB: font_c = 7'h03;
      4'hC: font_c = 7'h46;
      4'hD: font_c = 7'h21;
      4'hE: font_c = 7'h06;
      4'hF: font_c = 7'h0E;
      default: font_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_seg_scan.sv
// Four-digit multiplexed hex display driver with per-slot dead time and a
// frame-aligned shadow value. Optional leading-zero blanking: HEX_SEG_LEAD_ZERO_BLANK_EN.
module hex_seg_scan
  import hexcnt_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DEAD_CYC = 500
) (
  input  logic           clk,
  input  logic           reset,
  hex_seg_scan_if.slave  bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]     presc;
  logic [1:0]        idx;
  scan_state_e       state, state_nxt;
  logic [VAL_W-1:0]  pending, shown;
  logic [SEG_W-1:0]  seg_q;
  logic              frame_q;

  logic              wrap_c;
  logic              frame_c;
  logic [NIB_W-1:0]  nib_c;
  logic [FONT_W-1:0] font_c;
  logic [DIG_N-1:0]  lit_c;
  logic [DIG_N-1:0]  an_c;
  logic [SEG_W-1:0]  seg_nxt_c;

  assign wrap_c  = (presc == PW'(SCAN_DIV - 1));
  assign frame_c = wrap_c && (idx == 2'd3);
  assign nib_c   = shown[{idx, 2'b00} +: NIB_W];

  hex_to_seg7 u_font (
    .nib    (nib_c),
    .font_c (font_c)
  );

`ifdef HEX_SEG_LEAD_ZERO_BLANK_EN
  assign lit_c = lead_lit(shown) | bus.dp_mask;
`else
  assign lit_c = 4'hF;
`endif

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (wrap_c) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_DEAD;
    else       state <= state_nxt;
  end

  // Next state and anode pattern for the current slot
  always_comb begin
    state_nxt = state;
    an_c      = 4'hF;
    case (state)
      ST_DEAD: begin
        if (presc == PW'(DEAD_CYC - 1)) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (lit_c[idx]) an_c = ~(4'(4'b0001 << idx));
        if (wrap_c) state_nxt = ST_DEAD;
      end
      default: state_nxt = ST_DEAD;
    endcase
    if (bus.blank) an_c = 4'hF;
  end

  always_comb begin
    seg_nxt_c                = SEG_OFF;
    seg_nxt_c[AN_MSB:AN_LSB] = an_c;
    seg_nxt_c[DP_BIT]        = ~bus.dp_mask[idx];
    seg_nxt_c[FONT_W-1:0]    = font_c;
  end

  // Shown only changes on the frame boundary so a frame is never torn
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      shown   <= '0;
    end else begin
      if (frame_c)  shown   <= pending;
      if (bus.load) pending <= bus.value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_nxt_c;
      frame_q <= frame_c;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_hex_seg_scan.sv
// Self-checking bench for hex_seg_scan against a cycle-count based display model.
module tb_hex_seg_scan;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned DEAD_CYC  = 2;
  localparam int unsigned FRAME_LEN = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hex_seg_scan_if bus ();

  hex_seg_scan #(.SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: elapsed cycles since reset define slot and offset directly
  int          t = 0;
  logic [15:0] m_pending = '0;
  logic [15:0] m_shown = '0;
  int          cyc = 0;
  int          last_frame = -1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit digit_lit(input int slot);
`ifdef HEX_SEG_LEAD_ZERO_BLANK_EN
    return (slot == 0) || bus.dp_mask[slot] || ((m_shown >> (4 * slot)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] model_seg();
    int slot = (t / SCAN_DIV) % 4;
    int off  = t % SCAN_DIV;
    int dig  = int'((m_shown >> (4 * slot)) & 16'hF);
    logic [3:0] an = 4'hF;
    logic [7:0] f  = font[dig];
    if (off >= DEAD_CYC && !bus.blank && digit_lit(slot)) an = ~(4'b0001 << slot);
    return {an, ~bus.dp_mask[slot], f[6:0]};
  endfunction

  task automatic step();
    logic [11:0] e_seg;
    logic        e_frame;
    e_seg   = reset ? 12'hFFF : model_seg();
    e_frame = !reset && ((t % FRAME_LEN) == FRAME_LEN - 1);
    @(posedge clk);
    if (reset) begin
      t = 0; m_pending = '0; m_shown = '0; last_frame = -1;
    end else begin
      if (e_frame) m_shown = m_pending;
      if (bus.load) m_pending = bus.value;
      t++;
    end
    cyc++;
    #1;
    check("seg", 16'(bus.seg), 16'(e_seg));
    check("frame", 16'(bus.frame), 16'(e_frame));
    if (bus.frame === 1'b1) begin
      if (last_frame >= 0) check("frame_period", 16'(cyc - last_frame), 16'(FRAME_LEN));
      last_frame = cyc;
    end
  endtask

  task automatic load(input logic [15:0] v);
    bus.value = v; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < FRAME_LEN + 8 && !seen; i++) begin
      step();
      if (bus.frame === 1'b1) seen = 1'b1;
    end
    check("wait_frame", 16'(seen), 16'd1);
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1; bus.value = '0; bus.load = 1'b0; bus.dp_mask = '0; bus.blank = 1'b0;

    // 1: reset and first frame latency
    repeat (10) step();
    check("reset_seg", 16'(bus.seg), 16'h0FFF);
    reset = 1'b0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(); n++;
      if (bus.frame === 1'b1) seen = 1'b1;
    end
    check("first_frame", 16'(n), 16'd32);

    // 2: 12AF, slot contents and dead time
    load(16'h12AF);
    wait_frame();
    for (int k = 1; k <= int'(FRAME_LEN); k++) begin
      step();
      if (((k - 1) % SCAN_DIV) < DEAD_CYC) check("dead_an", 16'(bus.seg[11:8]), 16'hF);
      case (bus.seg[11:8])
        4'b1110: check("digF", 16'(bus.seg[7:0]), 16'h8E);
        4'b1101: check("digA", 16'(bus.seg[7:0]), 16'h88);
        4'b1011: check("dig2", 16'(bus.seg[7:0]), 16'hA4);
        4'b0111: check("dig1", 16'(bus.seg[7:0]), 16'hF9);
        default: ;
      endcase
    end

    // 3: latest load wins, no torn frame
    load(16'h1111);
    wait_frame();
    repeat (10) step();
    load(16'h2222);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (bus.frame === 1'b1) seen = 1'b1;
      else if (bus.seg[11:8] != 4'hF) check("old_frame", 16'(bus.seg[6:0]), 16'h79);
    end
    check("wait_frame2", 16'(seen), 16'd1);
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      step();
      if (bus.seg[11:8] != 4'hF) check("new_frame", 16'(bus.seg[6:0]), 16'h24);
    end

    // 4: blank mid-frame, phase kept
    repeat (5) step();
    bus.blank = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      check("blank_an", 16'(bus.seg[11:8]), 16'hF);
    end
    bus.blank = 1'b0;
    repeat (70) step();

    // 5: decimal point on digit2
    bus.dp_mask = 4'b0100;
    step();
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.seg[11:8] == 4'b1011) check("dp_on", 16'(bus.seg[7]), 16'd0);
      else if (bus.seg[11:8] != 4'hF) check("dp_off", 16'(bus.seg[7]), 16'd1);
    end
    bus.dp_mask = 4'b0000;

    // Randomized loads, DP and blanking against the model
    for (int k = 0; k < 400; k++) begin
      bus.load    = ($urandom_range(0, 7) == 0);
      bus.value   = 16'($urandom);
      bus.blank   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) bus.dp_mask = 4'($urandom);
      step();
    end
    bus.load = 1'b0; bus.blank = 1'b0; bus.dp_mask = '0;

`ifdef HEX_SEG_LEAD_ZERO_BLANK_EN
    // 6: leading zeros blanked
    load(16'h0005);
    wait_frame();
    for (int k = 0; k < int'(2 * FRAME_LEN); k++) begin
      step();
      if (bus.seg[11:8] != 4'hF) check("lzb_only_d0", 16'(bus.seg[11:8]), 16'hE);
    end
`endif

    // Reset mid-frame
    repeat (13) step();
    reset = 1'b1;
    step();
    check("mid_reset_seg", 16'(bus.seg), 16'h0FFF);
    check("mid_reset_frame", 16'(bus.frame), 16'd0);
    reset = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
